// File: rtl/uart_param_if_if.sv
// Byte-stream side bundle of uart_param_if: TX push port, RX pop port, fill levels.
// master = transport logic driving WE_I/DSEND_I/RE_I; slave = the UART itself.
interface uart_param_if_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic              WE_I;
    logic [DATA_W-1:0] DSEND_I;
    logic              TX_READY_O;
    logic [LW-1:0]     TX_LEVEL_O;
    logic              RE_I;
    logic [DATA_W-1:0] DREC_O;
    logic              RX_VALID_O;
    logic              RX_FULL_O;
    logic [LW-1:0]     RX_LEVEL_O;

    modport master (
        output WE_I, DSEND_I, RE_I,
        input  TX_READY_O, TX_LEVEL_O, DREC_O,
        input  RX_VALID_O, RX_FULL_O, RX_LEVEL_O
    );

    modport slave (
        input  WE_I, DSEND_I, RE_I,
        output TX_READY_O, TX_LEVEL_O, DREC_O,
        output RX_VALID_O, RX_FULL_O, RX_LEVEL_O
    );
endinterface

// File: rtl/uart_param_if.sv
// Parametrised UART: TX/RX FIFOs, serialiser/deserialiser, sticky error flags, loopback.
// Ports: CLK_I/RST_I (async active-high), bus (slave: WE_I, DSEND_I, TX_READY_O,
//   TX_LEVEL_O, RE_I, DREC_O, RX_VALID_O, RX_FULL_O, RX_LEVEL_O), RX_I/TX_O serial pins,
//   LOOPBACK_I, CLR_ERR_I, FRAME_ERR_O, OVERRUN_O.
// Optional: define UART_PARITY_EN to add parameter PARITY_ODD and port PARITY_ERR_O.
module uart_param_if #(
    parameter int CLK_RATE   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
`ifdef UART_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic CLK_I,
    input  logic RST_I,
    uart_param_if_if.slave bus,
    input  logic RX_I,
    output logic TX_O,
    input  logic LOOPBACK_I,
    input  logic CLR_ERR_I,
`ifdef UART_PARITY_EN
    output logic PARITY_ERR_O,
`endif
    output logic FRAME_ERR_O,
    output logic OVERRUN_O
);
    localparam int BIT_T  = CLK_RATE / BAUD_RATE;
    localparam int HALF_T = BIT_T / 2;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = AW + 1;
    localparam int TW     = $clog2(BIT_T);
    localparam int IW     = 4;

    localparam logic [TW-1:0] T_LAST = TW'(BIT_T - 1);
    localparam logic [TW-1:0] H_LAST = TW'(HALF_T - 1);
    // Ends one cycle early so IDLE is already armed when a back-to-back start edge lands.
    localparam logic [TW-1:0] TAIL_LAST = TW'(HALF_T - 2);
    localparam logic [IW-1:0] D_LAST = IW'(DATA_W - 1);
    localparam logic [IW-1:0] S_LAST = IW'(STOP_BITS - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    if (BIT_T < 16) begin : g_bad_baud
        $error("uart_param_if: CLK_RATE/BAUD_RATE must be at least 16");
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_width
        $error("uart_param_if: DATA_W must be 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_param_if: FIFO_DEPTH must be a power of 2, >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_param_if: STOP_BITS must be 1 or 2");
    end

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] txm_q [FIFO_DEPTH];
    logic [AW-1:0]     txw_q, txr_q;
    logic [LW-1:0]     txc_q;
    logic              tx_full, tx_empty, tx_push, tx_pop;
    logic [DATA_W-1:0] tx_head;

    assign tx_full  = (txc_q == FULL_LVL);
    assign tx_empty = (txc_q == '0);
    assign tx_push  = bus.WE_I && !tx_full;
    assign tx_head  = txm_q[txr_q];

    always_ff @(posedge CLK_I) begin
        if (tx_push) txm_q[txw_q] <= bus.DSEND_I;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            txw_q <= '0;
            txr_q <= '0;
            txc_q <= '0;
        end else begin
            if (tx_push) txw_q <= txw_q + AW'(1);
            if (tx_pop)  txr_q <= txr_q + AW'(1);
            unique case ({tx_push, tx_pop})
                2'b10:   txc_q <= txc_q + LW'(1);
                2'b01:   txc_q <= txc_q - LW'(1);
                default: txc_q <= txc_q;
            endcase
        end
    end

    assign bus.TX_READY_O = !tx_full;
    assign bus.TX_LEVEL_O = txc_q;

    // ---------------- TX FSM ----------------
    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA, T_STOP
`ifdef UART_PARITY_EN
        , T_PAR
`endif
    } tx_st_t;

    tx_st_t            txs_q, txs_d;
    logic [TW-1:0]     ttm_q, ttm_d;
    logic [IW-1:0]     tix_q, tix_d;
    logic [DATA_W-1:0] tsh_q, tsh_d;
    logic              tx_line_q, tx_line_d;
    logic              t_end;
`ifdef UART_PARITY_EN
    logic              tpar_q, tpar_d;
`endif

    assign t_end = (ttm_q == T_LAST);

    always_comb begin
        txs_d  = txs_q;
        ttm_d  = ttm_q;
        tix_d  = tix_q;
        tsh_d  = tsh_q;
        tx_pop = 1'b0;
`ifdef UART_PARITY_EN
        tpar_d = tpar_q;
`endif
        if (txs_q != T_IDLE) ttm_d = t_end ? '0 : ttm_q + TW'(1);
        unique case (txs_q)
            T_IDLE: begin
                if (!tx_empty) begin
                    tx_pop = 1'b1;
                    tsh_d  = tx_head;
                    ttm_d  = '0;
                    txs_d  = T_START;
`ifdef UART_PARITY_EN
                    tpar_d = (^tx_head) ^ PARITY_ODD;
`endif
                end
            end
            T_START: begin
                if (t_end) begin
                    tix_d = '0;
                    txs_d = T_DATA;
                end
            end
            T_DATA: begin
                if (t_end) begin
                    tsh_d = tsh_q >> 1;
                    if (tix_q == D_LAST) begin
                        tix_d = '0;
`ifdef UART_PARITY_EN
                        txs_d = T_PAR;
`else
                        txs_d = T_STOP;
`endif
                    end else begin
                        tix_d = tix_q + IW'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            T_PAR: begin
                if (t_end) begin
                    tix_d = '0;
                    txs_d = T_STOP;
                end
            end
`endif
            T_STOP: begin
                if (t_end) begin
                    if (tix_q == S_LAST) begin
                        if (!tx_empty) begin
                            tx_pop = 1'b1;
                            tsh_d  = tx_head;
                            txs_d  = T_START;
`ifdef UART_PARITY_EN
                            tpar_d = (^tx_head) ^ PARITY_ODD;
`endif
                        end else begin
                            txs_d = T_IDLE;
                        end
                    end else begin
                        tix_d = tix_q + IW'(1);
                    end
                end
            end
            default: txs_d = T_IDLE;
        endcase
    end

    // Line is registered from the current state, so it trails the state by one cycle.
    always_comb begin
        tx_line_d = 1'b1;
        unique case (txs_q)
            T_START: tx_line_d = 1'b0;
            T_DATA:  tx_line_d = tsh_q[0];
`ifdef UART_PARITY_EN
            T_PAR:   tx_line_d = tpar_q;
`endif
            default: tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            txs_q     <= T_IDLE;
            ttm_q     <= '0;
            tix_q     <= '0;
            tsh_q     <= '0;
            tx_line_q <= 1'b1;
`ifdef UART_PARITY_EN
            tpar_q    <= 1'b0;
`endif
        end else begin
            txs_q     <= txs_d;
            ttm_q     <= ttm_d;
            tix_q     <= tix_d;
            tsh_q     <= tsh_d;
            tx_line_q <= tx_line_d;
`ifdef UART_PARITY_EN
            tpar_q    <= tpar_d;
`endif
        end
    end

    // ---------------- RX input / loopback ----------------
    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_STOP, R_TAIL, R_WAIT
`ifdef UART_PARITY_EN
        , R_PAR
`endif
    } rx_st_t;

    rx_st_t rxs_q, rxs_d;
    logic   rs1_q, rs2_q, rprev_q, loop_q;
    logic   rx_in, rx_fall;

    assign rx_in   = loop_q ? tx_line_q : rs2_q;
    assign rx_fall = rprev_q && !rx_in;
    assign TX_O    = loop_q ? 1'b1 : tx_line_q;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rs1_q   <= 1'b1;
            rs2_q   <= 1'b1;
            rprev_q <= 1'b1;
            loop_q  <= 1'b0;
        end else begin
            rs1_q   <= RX_I;
            rs2_q   <= rs1_q;
            rprev_q <= rx_in;
            if (txs_q == T_IDLE && rxs_q == R_IDLE) loop_q <= LOOPBACK_I;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_W-1:0] rxm_q [FIFO_DEPTH];
    logic [AW-1:0]     rxw_q, rxr_q;
    logic [LW-1:0]     rxc_q;
    logic              rx_full, rx_empty, rx_push, rx_pop;
    logic              rx_word, frame_set, ovr_set;
    logic [DATA_W-1:0] rsh_q, rsh_d;

    assign rx_full  = (rxc_q == FULL_LVL);
    assign rx_empty = (rxc_q == '0);
    assign rx_pop   = bus.RE_I && !rx_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign rx_push  = rx_word && (!rx_full || rx_pop);
    assign ovr_set  = rx_word && rx_full && !rx_pop;

    always_ff @(posedge CLK_I) begin
        if (rx_push) rxm_q[rxw_q] <= rsh_q;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rxw_q <= '0;
            rxr_q <= '0;
            rxc_q <= '0;
        end else begin
            if (rx_push) rxw_q <= rxw_q + AW'(1);
            if (rx_pop)  rxr_q <= rxr_q + AW'(1);
            unique case ({rx_push, rx_pop})
                2'b10:   rxc_q <= rxc_q + LW'(1);
                2'b01:   rxc_q <= rxc_q - LW'(1);
                default: rxc_q <= rxc_q;
            endcase
        end
    end

    assign bus.DREC_O     = rx_empty ? '0 : rxm_q[rxr_q];
    assign bus.RX_VALID_O = !rx_empty;
    assign bus.RX_FULL_O  = rx_full;
    assign bus.RX_LEVEL_O = rxc_q;

    // ---------------- RX FSM ----------------
    logic [TW-1:0] rtm_q, rtm_d;
    logic [IW-1:0] rix_q, rix_d;
    logic          r_end;
`ifdef UART_PARITY_EN
    logic          rperr_q, rperr_d, par_set;
`endif

    assign r_end = (rtm_q == T_LAST);

    always_comb begin
        rxs_d     = rxs_q;
        rtm_d     = rtm_q;
        rix_d     = rix_q;
        rsh_d     = rsh_q;
        rx_word   = 1'b0;
        frame_set = 1'b0;
`ifdef UART_PARITY_EN
        rperr_d   = rperr_q;
        par_set   = 1'b0;
`endif
        if (rxs_q != R_IDLE && rxs_q != R_WAIT) rtm_d = rtm_q + TW'(1);
        unique case (rxs_q)
            R_IDLE: begin
                rtm_d = '0;
                if (rx_fall) rxs_d = R_START;
            end
            R_START: begin
                if (rtm_q == H_LAST) begin
                    rtm_d = '0;
                    rix_d = '0;
                    rxs_d = rx_in ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (r_end) begin
                    rtm_d = '0;
                    rsh_d = {rx_in, rsh_q[DATA_W-1:1]};
                    if (rix_q == D_LAST) begin
`ifdef UART_PARITY_EN
                        rxs_d = R_PAR;
`else
                        rxs_d = R_STOP;
`endif
                    end else begin
                        rix_d = rix_q + IW'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            R_PAR: begin
                if (r_end) begin
                    rtm_d   = '0;
                    rperr_d = (^rsh_q) ^ rx_in ^ PARITY_ODD;
                    rxs_d   = R_STOP;
                end
            end
`endif
            R_STOP: begin
                if (r_end) begin
                    rtm_d     = '0;
                    frame_set = !rx_in;
`ifdef UART_PARITY_EN
                    par_set   = rperr_q;
                    rx_word   = rx_in && !rperr_q;
`else
                    rx_word   = rx_in;
`endif
                    rxs_d     = rx_in ? R_TAIL : R_WAIT;
                end
            end
            R_TAIL: begin
                if (rtm_q == TAIL_LAST) rxs_d = R_IDLE;
            end
            R_WAIT: begin
                rtm_d = '0;
                if (rx_in) rxs_d = R_IDLE;
            end
            default: rxs_d = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            rxs_q   <= R_IDLE;
            rtm_q   <= '0;
            rix_q   <= '0;
            rsh_q   <= '0;
`ifdef UART_PARITY_EN
            rperr_q <= 1'b0;
`endif
        end else begin
            rxs_q   <= rxs_d;
            rtm_q   <= rtm_d;
            rix_q   <= rix_d;
            rsh_q   <= rsh_d;
`ifdef UART_PARITY_EN
            rperr_q <= rperr_d;
`endif
        end
    end

    // ---------------- Sticky flags (set beats clear) ----------------
    logic ferr_q, ovr_q;
`ifdef UART_PARITY_EN
    logic perr_q;
`endif

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else begin
            if (frame_set)      ferr_q <= 1'b1;
            else if (CLR_ERR_I) ferr_q <= 1'b0;
            if (ovr_set)        ovr_q  <= 1'b1;
            else if (CLR_ERR_I) ovr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            if (par_set)        perr_q <= 1'b1;
            else if (CLR_ERR_I) perr_q <= 1'b0;
`endif
        end
    end

    assign FRAME_ERR_O = ferr_q;
    assign OVERRUN_O   = ovr_q;
`ifdef UART_PARITY_EN
    assign PARITY_ERR_O = perr_q;
`endif
endmodule

// File: tb/tb_uart_param_if.sv
// Directed self-checking bench for uart_param_if (BIT_T = 16, 8 data bits, depth 16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_param_if;
    localparam int BT = 16;

    logic CLK_I = 1'b0;
    logic RST_I;
    logic RX_I, TX_O, LOOPBACK_I, CLR_ERR_I, FRAME_ERR_O, OVERRUN_O;
`ifdef UART_PARITY_EN
    logic PARITY_ERR_O;
    logic par_flip;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 CLK_I = ~CLK_I;

    uart_param_if_if #(.DATA_W(8), .FIFO_DEPTH(16)) bus ();

    uart_param_if #(
        .CLK_RATE(1_600_000), .BAUD_RATE(100_000),
        .DATA_W(8), .FIFO_DEPTH(16), .STOP_BITS(1)
    ) dut (
        .CLK_I(CLK_I),
        .RST_I(RST_I),
        .bus(bus),
        .RX_I(RX_I),
        .TX_O(TX_O),
        .LOOPBACK_I(LOOPBACK_I),
        .CLR_ERR_I(CLR_ERR_I),
`ifdef UART_PARITY_EN
        .PARITY_ERR_O(PARITY_ERR_O),
`endif
        .FRAME_ERR_O(FRAME_ERR_O),
        .OVERRUN_O(OVERRUN_O)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK_I);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopv);
        logic [7:0] dd;
        dd = d;
        RX_I = 1'b0;
        tick(BT);
        for (int i = 0; i < 8; i++) begin
            RX_I = dd[i];
            tick(BT);
        end
`ifdef UART_PARITY_EN
        RX_I = (^dd) ^ par_flip;
        tick(BT);
`endif
        RX_I = stopv;
        tick(BT);
        RX_I = 1'b1;
        tick(BT);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] exp_line;
        int nb;
        int cyc;
        logic txlow;

        RST_I = 1'b1;
        bus.WE_I = 1'b0;
        bus.DSEND_I = '0;
        bus.RE_I = 1'b0;
        RX_I = 1'b1;
        LOOPBACK_I = 1'b0;
        CLR_ERR_I = 1'b0;
`ifdef UART_PARITY_EN
        par_flip = 1'b0;
`endif
        tick(3);

        chk("rst_tx_o", 32'(TX_O), 1);
        chk("rst_tx_ready", 32'(bus.TX_READY_O), 1);
        chk("rst_tx_level", 32'(bus.TX_LEVEL_O), 0);
        chk("rst_rx_valid", 32'(bus.RX_VALID_O), 0);
        chk("rst_rx_full", 32'(bus.RX_FULL_O), 0);
        chk("rst_rx_level", 32'(bus.RX_LEVEL_O), 0);
        chk("rst_drec", 32'(bus.DREC_O), 0);
        chk("rst_ferr", 32'(FRAME_ERR_O), 0);
        chk("rst_ovr", 32'(OVERRUN_O), 0);
        RST_I = 1'b0;
        tick(2);

        // 1: serialise 0xA5
`ifdef UART_PARITY_EN
        exp_line = {1'b1, 1'b0, 8'hA5, 1'b0};
        nb = 11;
`else
        exp_line = {1'b0, 1'b1, 8'hA5, 1'b0};
        nb = 10;
`endif
        bus.WE_I = 1'b1;
        bus.DSEND_I = 8'hA5;
        tick(1);
        bus.WE_I = 1'b0;
        tick(1);
        chk("tx_idle_before_start", 32'(TX_O), 1);
        tick(1);
        chk("tx_start_edge", 32'(TX_O), 0);
        tick(8);
        for (int b = 0; b < nb; b++) begin
            chk($sformatf("tx_bit%0d", b), 32'(TX_O), 32'(exp_line[b]));
            tick(BT);
        end
        tick(20);
        chk("tx_idle_after", 32'(TX_O), 1);
        chk("tx_level_after", 32'(bus.TX_LEVEL_O), 0);

        // 2: loopback 16 words
        LOOPBACK_I = 1'b1;
        tick(2);
        for (int i = 0; i < 16; i++) begin
            bus.WE_I = 1'b1;
            bus.DSEND_I = 8'(i);
            tick(1);
        end
        bus.WE_I = 1'b0;
        cyc = 0;
        txlow = 1'b0;
        while (bus.RX_LEVEL_O != 5'd16 && cyc < 4000) begin
            tick(1);
            cyc++;
            if (TX_O !== 1'b1) txlow = 1'b1;
        end
        chk("lb_rx_level", 32'(bus.RX_LEVEL_O), 16);
        chk("lb_rx_full", 32'(bus.RX_FULL_O), 1);
        chk("lb_tx_held_high", 32'(txlow), 0);
        chk("lb_no_overrun", 32'(OVERRUN_O), 0);
        chk("lb_head", 32'(bus.DREC_O), 0);
        LOOPBACK_I = 1'b0;
        tick(40);

        // 3: overrun with FIFO full
        send_frame(8'h55, 1'b1);
        chk("ovr_flag", 32'(OVERRUN_O), 1);
        chk("ovr_level", 32'(bus.RX_LEVEL_O), 16);
        chk("ovr_head", 32'(bus.DREC_O), 0);
        chk("ovr_no_ferr", 32'(FRAME_ERR_O), 0);
        CLR_ERR_I = 1'b1;
        tick(1);
        CLR_ERR_I = 1'b0;
        chk("ovr_cleared", 32'(OVERRUN_O), 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("pop%0d", i), 32'(bus.DREC_O), 32'(i));
            bus.RE_I = 1'b1;
            tick(1);
            bus.RE_I = 1'b0;
        end
        chk("drain_valid", 32'(bus.RX_VALID_O), 0);
        chk("drain_drec", 32'(bus.DREC_O), 0);
        chk("drain_level", 32'(bus.RX_LEVEL_O), 0);
        chk("drain_full", 32'(bus.RX_FULL_O), 0);

        // 4: framing error then good frame
        send_frame(8'h3C, 1'b0);
        chk("ferr_flag", 32'(FRAME_ERR_O), 1);
        chk("ferr_level", 32'(bus.RX_LEVEL_O), 0);
        send_frame(8'h11, 1'b1);
        chk("good_level", 32'(bus.RX_LEVEL_O), 1);
        chk("good_data", 32'(bus.DREC_O), 32'h11);
        chk("ferr_sticky", 32'(FRAME_ERR_O), 1);
        CLR_ERR_I = 1'b1;
        tick(1);
        CLR_ERR_I = 1'b0;
        chk("ferr_cleared", 32'(FRAME_ERR_O), 0);
        bus.RE_I = 1'b1;
        tick(1);
        bus.RE_I = 1'b0;

        // 5: glitch rejection, then a frame to prove RX is back in IDLE
        RX_I = 1'b0;
        tick(4);
        RX_I = 1'b1;
        tick(40);
        chk("glitch_level", 32'(bus.RX_LEVEL_O), 0);
        chk("glitch_ferr", 32'(FRAME_ERR_O), 0);
        chk("glitch_ovr", 32'(OVERRUN_O), 0);
        send_frame(8'hC3, 1'b1);
        chk("post_glitch_data", 32'(bus.DREC_O), 32'hC3);
        bus.RE_I = 1'b1;
        tick(1);
        bus.RE_I = 1'b0;

        // 5b: reset in the middle of a TX frame
        bus.WE_I = 1'b1;
        bus.DSEND_I = 8'h5A;
        tick(1);
        bus.DSEND_I = 8'hFF;
        tick(1);
        bus.WE_I = 1'b0;
        tick(57);
        chk("mid_frame_bit2", 32'(TX_O), 0);
        chk("mid_frame_level", 32'(bus.TX_LEVEL_O), 1);
        RST_I = 1'b1;
        #1;
        chk("rst_async_tx_o", 32'(TX_O), 1);
        chk("rst_async_level", 32'(bus.TX_LEVEL_O), 0);
        chk("rst_async_ready", 32'(bus.TX_READY_O), 1);
        tick(2);
        RST_I = 1'b0;
        tick(2);

`ifdef UART_PARITY_EN
        // 6: even parity check
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        chk("perr_flag", 32'(PARITY_ERR_O), 1);
        chk("perr_level", 32'(bus.RX_LEVEL_O), 0);
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        chk("par_ok_level", 32'(bus.RX_LEVEL_O), 1);
        chk("par_ok_data", 32'(bus.DREC_O), 32'h07);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
